imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Synthesizable successor to bench-side program loading: streams instruction words into the CPU instruction RAM over a valid/ready handshake, optionally pads the remainder, then releases CPU reset.
- Parametrised in word width, memory depth, fill word and release delay.
- Supports reload from the RUN state.
- Sits between an external loader (UART/JTAG/bench) and the instruction RAM write port plus the CPU reset input.

Parameters:
- WORD_W, 32, instruction word width.
- DEPTH, 64, instruction RAM words (power of 2, >=2).
- ADDR_W, $clog2(DEPTH), word address width.
- FILL_WORD, 32'h0000_0000, pad value (NOP) written after the last word.
- RELEASE_DLY, 4, cycles between entering RUN and deasserting cpu_reset (>=1).

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts word this cycle.
- in_data  in  WORD_W  instruction word.
- in_last  in  1  qualifies the final word of the image.
- reload  in  1  single-cycle pulse; restarts loading (honoured only in RUN or ERROR).
- mem_we  out  1  instruction RAM write enable.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  WORD_W  RAM write data.
- cpu_reset  out  1  active-high CPU reset.
- done  out  1  image loaded, CPU running.
- error  out  1  overflow or checksum failure.
- word_count  out  ADDR_W+1  number of program words written this load.

Behaviour:
- Reset state (RESET_N=0, asynchronous):
  - state=LOAD.
  - in_ready=0 during reset, then 1 in LOAD.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, done=0, error=0, word_count=0.
- Outputs: all registered.
  - in_ready=1 only in LOAD.
  - mem_we/mem_addr/mem_wdata appear one cycle after the accept or fill step.
- LOAD state:
  - On accept (in_valid&&in_ready): write in_data at address word_count, then word_count++.
  - in_valid with in_ready=0 is held by the source; data must stay stable until accepted.
  - Accept with in_last=1 and word_count+1<DEPTH: go to FILL at the next address.
  - Accept with in_last=1 filling the final address (DEPTH-1): go straight to RUN.
  - word_count==DEPTH with no in_last seen, and another word presented: word is not written, error=1, go to ERROR.
- FILL state:
  - Write FILL_WORD at each address from word_count to DEPTH-1, one word per cycle.
  - word_count does not change.
  - After the DEPTH-1 write, go to RUN.
- RUN state:
  - Internal counter counts RELEASE_DLY cycles.
  - Then cpu_reset=0 and done=1, held until reload or reset.
- ERROR state:
  - cpu_reset=1, in_ready=0.
  - error stays 1 until reload or reset.
- reload pulse (RUN or ERROR):
  - Next cycle: state=LOAD, cpu_reset=1, done=0, error=0, word_count=0, delay counter cleared.
  - reload in LOAD or FILL is ignored.
- in_valid&&in_last with in_data accepted on the same cycle as a reload pulse: impossible, because in_ready=0 outside LOAD.
- Asynchronous reset mid-load or mid-fill:
  - Aborts immediately and returns to reset values.
  - RAM contents are not cleared.
- mem_addr wraps only by construction: it never exceeds DEPTH-1.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - The in_last word is a trailer, not a program word, and is not written; word_count excludes it.
  - A running XOR of accepted program words is compared with the trailer.
  - Match: FILL/RUN as normal.
  - Mismatch: error=1, go to ERROR, cpu_reset held.
  - A trailer arriving when word_count==DEPTH is legal.
- Undefined:
  - The in_last word is an ordinary program word.
  - No checksum logic is synthesized.

Test Plan:
- 3-word image 0x20080005, 0x20090003, 0x01095020 (last on third), DEPTH=64 -> RAM[0..2] hold the words, RAM[3..63]=0, word_count=3, cpu_reset falls RELEASE_DLY cycles after the addr-63 write, done=1.
- Exactly 64 words, last on word 64 -> no FILL writes, RUN entered directly, error=0.
- 65 words, no last -> 65th not written, error=1, cpu_reset stays 1; reload pulse -> in_ready=1, error=0, word_count=0.
- in_valid toggled 1/0 randomly during LOAD -> writes only on handshake cycles, addresses contiguous.
- RESET_N asserted after 10 words -> outputs at reset values within the same cycle; a new 2-word load then completes correctly.
- With IMEM_BOOT_CHECKSUM_EN: words 0x1, 0x2, trailer 0x3 -> done=1; trailer 0x4 -> error=1, done=0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams an instruction image into the CPU instruction RAM
// over a valid/ready handshake, pads unused words with FILL_WORD, then
// releases the CPU reset RELEASE_DLY cycles after the last RAM write.
// A reload pulse in RUN or ERROR restarts the load.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN. When defined, the in_last
// word is an XOR checksum trailer checked against the program words and is
// not written to RAM.

module imem_boot_loader #(
  parameter int unsigned          WORD_W      = 32,
  parameter int unsigned          DEPTH       = 64,
  parameter int unsigned          ADDR_W      = $clog2(DEPTH),
  parameter logic [WORD_W-1:0]    FILL_WORD   = WORD_W'(32'h0000_0000),
  parameter int unsigned          RELEASE_DLY = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DLY_W = $clog2(RELEASE_DLY + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_CNT_C  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR_C = ADDR_W'(DEPTH - 1);
  localparam logic [DLY_W-1:0]  DLY_END_C   = DLY_W'(RELEASE_DLY - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  state_e              state_q, state_d;

  logic                in_ready_q,   in_ready_d;
  logic                mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic                cpu_reset_q,  cpu_reset_d;
  logic                done_q,       done_d;
  logic                error_q,      error_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d;
  logic [ADDR_W-1:0]   fill_addr_q,  fill_addr_d;
  logic [DLY_W-1:0]    dly_cnt_q,    dly_cnt_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [WORD_W-1:0]   csum_q,       csum_d;
`endif

  logic accept_c;
  logic full_c;
  logic wr_prog_c;

  // Handshake and program-word qualification
  assign accept_c = in_valid && in_ready_q && (state_q == ST_LOAD);
  assign full_c   = (word_count_q == DEPTH_C);
`ifdef IMEM_BOOT_CHECKSUM_EN
  assign wr_prog_c = accept_c && !in_last && !full_c;
`else
  assign wr_prog_c = accept_c && !full_c;
`endif

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: begin
        if (accept_c) begin
          if (in_last) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            // Trailer: checksum decides, then pad or run
            if (csum_q != in_data) begin
              state_d = ST_ERROR;
            end else if (full_c) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_FILL;
            end
`else
            // Final program word: pad unless it filled the last address
            if (full_c) begin
              state_d = ST_ERROR;
            end else if (word_count_q == LAST_CNT_C) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_FILL;
            end
`endif
          end else if (full_c) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_FILL: begin
        if (fill_addr_q == LAST_ADDR_C) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_ERROR: begin
        if (reload) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    error_d      = error_q;
    word_count_d = word_count_q;
    fill_addr_d  = fill_addr_q;
    dly_cnt_d    = dly_cnt_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    unique case (state_q)
      ST_LOAD: begin
        if (wr_prog_c) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = word_count_q[ADDR_W-1:0];
          mem_wdata_d  = in_data;
          word_count_d = word_count_q + CNT_W'(1);
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum_d       = csum_q ^ in_data;
`endif
        end
        // Padding starts at the first address not holding a program word
        if (state_d == ST_FILL) begin
          fill_addr_d = word_count_d[ADDR_W-1:0];
        end
        if (state_d == ST_ERROR) begin
          error_d     = 1'b1;
          cpu_reset_d = 1'b1;
        end
      end
      ST_FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = fill_addr_q;
        mem_wdata_d = FILL_WORD;
        fill_addr_d = fill_addr_q + ADDR_W'(1);
      end
      ST_RUN, ST_ERROR: begin
        if (reload) begin
          cpu_reset_d  = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          word_count_d = '0;
          fill_addr_d  = '0;
          dly_cnt_d    = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum_d       = '0;
`endif
        end else if ((state_q == ST_RUN) && cpu_reset_q) begin
          // Hold the CPU in reset for RELEASE_DLY cycles after entering RUN
          if (dly_cnt_q == DLY_END_C) begin
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            dly_cnt_d = dly_cnt_q + DLY_W'(1);
          end
        end
      end
      default: ;
    endcase

    in_ready_d = (state_d == ST_LOAD);
  end

  // Registered outputs and datapath state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
      fill_addr_q  <= '0;
      dly_cnt_q    <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
      fill_addr_q  <= fill_addr_d;
      dly_cnt_q    <= dly_cnt_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: expected RAM writes are queued as stimulus
// is issued and a monitor pops/compares them on every mem_we cycle.
module tb_imem_boot_loader;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DLY    = 4;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              reload = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  imem_boot_loader #(
    .WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .FILL_WORD(32'h0000_0000), .RELEASE_DLY(DLY)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .reload(reload),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the head of the expected queue
  always @(negedge CLK) begin
    wr_t e;
    if (RESET_N && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  // Present one word (called at a negedge); returns at the negedge after acceptance
  task automatic send(input logic [31:0] d, input logic last, input bit wr, input int addr);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (wr) exp_q.push_back('{addr: ADDR_W'(addr), data: d});
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: in_ready still %b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic expect_fill(input int from);
    for (int a = from; a < int'(DEPTH); a++) exp_q.push_back('{addr: ADDR_W'(a), data: 32'h0});
  endtask

  // Wait for the addr DEPTH-1 write, then check cpu_reset falls exactly DLY cycles later
  task automatic wait_release(input string tag);
    int n;
    n = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (!(mem_we === 1'b1 && mem_addr == ADDR_W'(DEPTH - 1)) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s_last_write_timeout: no write to addr %0d within %0d cycles", tag, DEPTH - 1, n);
    end
    repeat (DLY - 1) @(negedge CLK);
    check({tag, "_cpu_reset_hold"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done_hold"},      32'(done),      32'd0);
    @(negedge CLK);
    check({tag, "_cpu_reset_rel"},  32'(cpu_reset), 32'd0);
    check({tag, "_done"},           32'(done),      32'd1);
    check({tag, "_error"},          32'(error),     32'd0);
    check({tag, "_in_ready"},       32'(in_ready),  32'd0);
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(negedge CLK);
    reload = 1'b0;
    check({tag, "_in_ready"},   32'(in_ready),   32'd1);
    check({tag, "_error"},      32'(error),      32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    check_reset_vals("rst");
    RESET_N = 1'b1;
    @(negedge CLK);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

`ifndef IMEM_BOOT_CHECKSUM_EN
    // 3-word image, padded to 64 words
    send(32'h2008_0005, 1'b0, 1'b1, 0);
    send(32'h2009_0003, 1'b0, 1'b1, 1);
    send(32'h0109_5020, 1'b1, 1'b1, 2);
    expect_fill(3);
    wait_release("img3");
    check("img3_word_count", 32'(word_count), 32'd3);
    idle(3);
    check("img3_done_stays", 32'(done), 32'd1);
    do_reload("rl1");

    // Exactly DEPTH words, last on the final one: no padding
    for (int i = 0; i < int'(DEPTH); i++)
      send(32'hA000_0000 | 32'(i), (i == int'(DEPTH) - 1), 1'b1, i);
    wait_release("full");
    check("full_word_count", 32'(word_count), 32'd64);
    idle(4);
    do_reload("rl2");

    // DEPTH+1 words, no last, random valid gaps: 65th not written, error
    for (int i = 0; i < int'(DEPTH); i++) begin
      idle(int'($urandom_range(0, 2)));
      send(32'hC000_0000 | 32'(i), 1'b0, 1'b1, i);
    end
    idle(int'($urandom_range(0, 2)));
    send(32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    in_valid = 1'b0;
    check("ovf_error",      32'(error),      32'd1);
    check("ovf_in_ready",   32'(in_ready),   32'd0);
    check("ovf_cpu_reset",  32'(cpu_reset),  32'd1);
    check("ovf_done",       32'(done),       32'd0);
    check("ovf_word_count", 32'(word_count), 32'd64);
    idle(DLY + 4);
    check("ovf_cpu_reset_held", 32'(cpu_reset), 32'd1);
    check("ovf_error_held",     32'(error),     32'd1);
    do_reload("rl3");

    // Asynchronous reset after 10 words, then a fresh 2-word load
    for (int i = 0; i < 10; i++) send(32'h5500_0000 | 32'(i), 1'b0, 1'b1, i);
    idle(1);
    #2 RESET_N = 1'b0;
    #1 check_reset_vals("arst");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    send(32'h0000_0011, 1'b0, 1'b1, 0);
    send(32'h0000_0022, 1'b1, 1'b1, 1);
    expect_fill(2);
    wait_release("img2");
    check("img2_word_count", 32'(word_count), 32'd2);
`else
    // Checksum match: 0x1 ^ 0x2 == 0x3
    send(32'h1, 1'b0, 1'b1, 0);
    send(32'h2, 1'b0, 1'b1, 1);
    send(32'h3, 1'b1, 1'b0, 0);
    expect_fill(2);
    wait_release("cs_ok");
    check("cs_ok_word_count", 32'(word_count), 32'd2);
    do_reload("cs_rl");

    // Checksum mismatch: trailer 0x4
    send(32'h1, 1'b0, 1'b1, 0);
    send(32'h2, 1'b0, 1'b1, 1);
    send(32'h4, 1'b1, 1'b0, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("cs_bad_error",      32'(error),      32'd1);
    check("cs_bad_done",       32'(done),       32'd0);
    check("cs_bad_word_count", 32'(word_count), 32'd2);
    idle(DLY + 4);
    check("cs_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("cs_bad_done_held", 32'(done),      32'd0);
`endif

    idle(3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
